// File: rtl/jtvigil_pkg.sv
//============================================================================
// jtvigil_pkg: shared FSM encoding and defaults for the sound command path
// Rev 1.0
//============================================================================
`default_nettype none

package jtvigil_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    localparam logic [15:0] JTVIGIL_SNDCMD_TO_DFLT = 16'd4096;

endpackage

`default_nettype wire

// File: rtl/jtvigil_sndcmd_fifo.sv
//============================================================================
// jtvigil_sndcmd_fifo: register-based byte FIFO, depth 2^AW
// Rev 1.0
//============================================================================
`default_nettype none

module jtvigil_sndcmd_fifo #(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_full,
    output logic       o_empty
);

    localparam int          C_DEPTH   = 2**AW;
    localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [C_DEPTH];

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    // Extra MSB tells a wrapped-full FIFO apart from an empty one
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop & ~w_empty;
    // A pop on the same edge frees the slot the push is about to take
    assign w_push_ok = i_push & (~w_full | w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/jtvigil_sndcmd.sv
//============================================================================
// jtvigil_sndcmd: main-CPU sound command transmitter with ack handshake.
// Optional ack timeout enabled by defining JTVIGIL_SNDCMD_TIMEOUT_EN.
// Rev 1.0
//============================================================================
`default_nettype none

module jtvigil_sndcmd
    import jtvigil_pkg::*;
#(
    parameter int          AW      = 2,
    parameter logic [15:0] TIMEOUT = JTVIGIL_SNDCMD_TO_DFLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       main_wr,
    input  logic [7:0] main_din,
    input  logic       snd_ack,
    input  logic       flag_clr,
    output logic       latch_wr,
    output logic [7:0] latch_dout,
    output logic       busy,
    output logic       full,
    output logic       ovf,
    output logic       tout
);

    state_t     r_state;
    logic       r_main_wr_l;
    logic       r_latch_wr;
    logic [7:0] r_latch_dout;
    logic       r_ovf;

    logic       w_rise;
    logic       w_pop;
    logic       w_drop;
    logic       w_to_hit;
    logic [7:0] w_head;
    logic       w_full;
    logic       w_empty;

    assign w_rise = main_wr & ~r_main_wr_l;
    assign w_pop  = (r_state == IDLE) & ~w_empty;
    assign w_drop = w_rise & w_full & ~w_pop;

    jtvigil_sndcmd_fifo #(
        .AW      (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rise),
        .i_din   (main_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef JTVIGIL_SNDCMD_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        r_tout;

    assign w_to_hit = (r_state == WAIT_ACK) & ~snd_ack & (r_to_cnt >= TIMEOUT);

    // Cleared on each send so every command gets a full window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_pop) begin
            r_to_cnt <= '0;
        end else if (r_state == WAIT_ACK && cen && !w_to_hit) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tout <= 1'b0;
        end else if (w_to_hit) begin
            r_tout <= 1'b1;
        end else if (flag_clr) begin
            r_tout <= 1'b0;
        end
    end

    assign tout = r_tout;
`else
    logic w_unused_to;

    assign w_unused_to = ^{TIMEOUT, cen};
    assign w_to_hit    = 1'b0;
    assign tout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_main_wr_l  <= 1'b0;
            r_latch_wr   <= 1'b0;
            r_latch_dout <= '0;
        end else begin
            r_main_wr_l <= main_wr;
            r_latch_wr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_latch_dout <= w_head;
                        r_latch_wr   <= 1'b1;
                        r_state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (snd_ack) begin
                        r_state <= RELEASE;
                    end else if (w_to_hit) begin
                        r_state <= IDLE;
                    end
                end
                // A long ack access must fall before the next byte goes out
                RELEASE: begin
                    if (!snd_ack) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (flag_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign latch_wr   = r_latch_wr;
    assign latch_dout = r_latch_dout;
    assign busy       = ~w_empty | (r_state != IDLE);
    assign full       = w_full;
    assign ovf        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_jtvigil_sndcmd.sv
//============================================================================
// tb_jtvigil_sndcmd: directed vector table plus hand-written corner sequences
// Rev 1.0
//============================================================================
`default_nettype none

module tb_jtvigil_sndcmd;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic       main_wr;
    logic [7:0] main_din;
    logic       snd_ack;
    logic       flag_clr;
    logic       latch_wr;
    logic [7:0] latch_dout;
    logic       busy;
    logic       full;
    logic       ovf;
    logic       tout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    jtvigil_sndcmd #(
        .AW         (2),
        .TIMEOUT    (16'd16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .main_wr    (main_wr),
        .main_din   (main_din),
        .snd_ack    (snd_ack),
        .flag_clr   (flag_clr),
        .latch_wr   (latch_wr),
        .latch_dout (latch_dout),
        .busy       (busy),
        .full       (full),
        .ovf        (ovf),
        .tout       (tout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       ack;
        logic       lw;
        logic [7:0] dout;
        logic       busy;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t mk(logic wr, logic [7:0] din, logic ack,
                                logic lw, logic [7:0] dout, logic bsy);
        vec_t v;
        v.wr = wr; v.din = din; v.ack = ack;
        v.lw = lw; v.dout = dout; v.busy = bsy;
        return v;
    endfunction

    // cen pulses once every 4 clocks
    task automatic tick();
        cen = (cyc % 4 == 3);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] b);
        main_wr  = 1'b1;
        main_din = b;
        tick();
        main_wr  = 1'b0;
        main_din = 8'h00;
        tick();
    endtask

    task automatic ack_expect(input string name, input logic [7:0] b);
        snd_ack = 1'b1;
        tick();
        snd_ack = 1'b0;
        tick();
        tick();
        chk1({name, "_lw"}, latch_wr, 1'b1);
        chk8({name, "_dout"}, latch_dout, b);
    endtask

    task automatic chk_all_zero(input string name);
        chk1({name, "_lw"}, latch_wr, 1'b0);
        chk8({name, "_dout"}, latch_dout, 8'h00);
        chk1({name, "_busy"}, busy, 1'b0);
        chk1({name, "_full"}, full, 1'b0);
        chk1({name, "_ovf"}, ovf, 1'b0);
        chk1({name, "_tout"}, tout, 1'b0);
    endtask

    initial begin
        int seen;
        int t0;

        // Single byte held 5 clocks, then 2-clock ack
        tbl[0]  = mk(1, 8'h3C, 0, 0, 8'h00, 1);
        tbl[1]  = mk(1, 8'h3C, 0, 1, 8'h3C, 1);
        tbl[2]  = mk(1, 8'h3C, 0, 0, 8'h3C, 1);
        tbl[3]  = mk(1, 8'h3C, 0, 0, 8'h3C, 1);
        tbl[4]  = mk(1, 8'h3C, 0, 0, 8'h3C, 1);
        tbl[5]  = mk(0, 8'h00, 1, 0, 8'h3C, 1);
        tbl[6]  = mk(0, 8'h00, 1, 0, 8'h3C, 1);
        tbl[7]  = mk(0, 8'h00, 0, 0, 8'h3C, 0);
        tbl[8]  = mk(0, 8'h00, 0, 0, 8'h3C, 0);
        // Burst 01/02/03; ack on the send edge is ignored, 4-clock ack counts once
        tbl[9]  = mk(1, 8'h01, 0, 0, 8'h3C, 1);
        tbl[10] = mk(0, 8'h00, 1, 1, 8'h01, 1);
        tbl[11] = mk(1, 8'h02, 0, 0, 8'h01, 1);
        tbl[12] = mk(0, 8'h00, 0, 0, 8'h01, 1);
        tbl[13] = mk(1, 8'h03, 0, 0, 8'h01, 1);
        tbl[14] = mk(0, 8'h00, 1, 0, 8'h01, 1);
        tbl[15] = mk(0, 8'h00, 1, 0, 8'h01, 1);
        tbl[16] = mk(0, 8'h00, 1, 0, 8'h01, 1);
        tbl[17] = mk(0, 8'h00, 1, 0, 8'h01, 1);
        tbl[18] = mk(0, 8'h00, 0, 0, 8'h01, 1);
        tbl[19] = mk(0, 8'h00, 0, 1, 8'h02, 1);
        tbl[20] = mk(0, 8'h00, 0, 0, 8'h02, 1);
        tbl[21] = mk(0, 8'h00, 1, 0, 8'h02, 1);
        tbl[22] = mk(0, 8'h00, 0, 0, 8'h02, 1);
        tbl[23] = mk(0, 8'h00, 0, 1, 8'h03, 1);
        tbl[24] = mk(0, 8'h00, 1, 0, 8'h03, 1);
        tbl[25] = mk(0, 8'h00, 0, 0, 8'h03, 0);
        tbl[26] = mk(0, 8'h00, 0, 0, 8'h03, 0);

        rst_n    = 1'b0;
        cen      = 1'b0;
        main_wr  = 1'b0;
        main_din = 8'h00;
        snd_ack  = 1'b0;
        flag_clr = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        #2 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 27; i++) begin
            main_wr  = tbl[i].wr;
            main_din = tbl[i].din;
            snd_ack  = tbl[i].ack;
            tick();
            chk1($sformatf("vec%0d_lw", i), latch_wr, tbl[i].lw);
            chk8($sformatf("vec%0d_dout", i), latch_dout, tbl[i].dout);
            chk1($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            chk1($sformatf("vec%0d_full", i), full, 1'b0);
            chk1($sformatf("vec%0d_ovf", i), ovf, 1'b0);
        end
        main_wr = 1'b0;
        snd_ack = 1'b0;

        // Overflow: A0 goes to the latch, A1..A4 fill depth 4, A5 is dropped
        pulse(8'hA0);
        chk1("ovf_a0_lw", latch_wr, 1'b1);
        chk8("ovf_a0_dout", latch_dout, 8'hA0);
        pulse(8'hA1);
        pulse(8'hA2);
        pulse(8'hA3);
        chk1("ovf_3q_full", full, 1'b0);
        pulse(8'hA4);
        chk1("ovf_4q_full", full, 1'b1);
        chk1("ovf_4q_ovf", ovf, 1'b0);
        pulse(8'hA5);
        chk1("ovf_5q_full", full, 1'b1);
        chk1("ovf_5q_ovf", ovf, 1'b1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk1("ovf_clr", ovf, 1'b0);

        // Push on the same edge as a pop while full is accepted
        snd_ack = 1'b1;
        tick();
        snd_ack = 1'b0;
        tick();
        main_wr  = 1'b1;
        main_din = 8'hB5;
        tick();
        main_wr  = 1'b0;
        chk1("pop_push_lw", latch_wr, 1'b1);
        chk8("pop_push_dout", latch_dout, 8'hA1);
        chk1("pop_push_full", full, 1'b1);
        chk1("pop_push_ovf", ovf, 1'b0);
        ack_expect("drain_a2", 8'hA2);
        ack_expect("drain_a3", 8'hA3);
        ack_expect("drain_a4", 8'hA4);
        ack_expect("drain_b5", 8'hB5);
        snd_ack = 1'b1;
        tick();
        snd_ack = 1'b0;
        tick();
        tick();
        chk1("drain_end_lw", latch_wr, 1'b0);
        chk1("drain_end_busy", busy, 1'b0);

        // Unacknowledged command: timeout behaviour depends on the build
        pulse(8'hC1);
        t0 = cyc - 1;
        chk8("to_c1_dout", latch_dout, 8'hC1);
        pulse(8'hC2);
        seen = 0;
`ifdef JTVIGIL_SNDCMD_TIMEOUT_EN
        for (int k = 0; k < 200 && seen == 0; k++) begin
            tick();
            if (latch_wr) seen = cyc - t0;
        end
        chk1("to_resend_seen", seen != 0, 1'b1);
        chk1("to_latency", (seen >= 60) && (seen <= 72), 1'b1);
        chk8("to_next_dout", latch_dout, 8'hC2);
        chk1("to_tout_set", tout, 1'b1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk1("to_tout_clr", tout, 1'b0);
`else
        for (int k = 0; k < 100; k++) begin
            tick();
            if (latch_wr) seen++;
        end
        chk1("noto_no_send", seen == 0, 1'b1);
        chk1("noto_busy", busy, 1'b1);
        chk8("noto_dout", latch_dout, 8'hC1);
        chk1("noto_tout", tout, 1'b0);
`endif

        // Reset during WAIT_ACK with two bytes queued
        #2 rst_n = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        tick();
        pulse(8'hD1);
        pulse(8'hD2);
        pulse(8'hD3);
        chk8("rst_pre_dout", latch_dout, 8'hD1);
        chk1("rst_pre_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        #2 rst_n = 1'b1;
        snd_ack = 1'b1;
        tick();
        snd_ack = 1'b0;
        tick();
        tick();
        chk1("rst_after_lw", latch_wr, 1'b0);
        chk1("rst_after_busy", busy, 1'b0);
        pulse(8'hE1);
        chk1("rst_new_lw", latch_wr, 1'b1);
        chk8("rst_new_dout", latch_dout, 8'hE1);
        #2 rst_n = 1'b0;
        #1;
        chk1("rst_strobe_lw", latch_wr, 1'b0);
        chk8("rst_strobe_dout", latch_dout, 8'h00);
        #2 rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
